pipeline_hazard_sequencer: RTL

//  Sequences the 5-stage pipeline: detects RAW hazards between ID and in-flight producers, stalls PC and IF/ID.

---
 rtl/pipeline_hazard_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_sequencer.sv
// Pipeline hazard sequencer: RAW stall, jump/branch flush and halt drain for a 5-stage pipe.
// Latency: outputs are combinational from state, scoreboard and ID inputs; scoreboard updates each clock.
// Backpressure: stalls PC and IF/ID on a hazard; FORWARDING_EN selects load-use-only hazard detection.
module pipeline_hazard_sequencer #(
    parameter int REG_AW       = 5,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_reg_write,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_mem_read,
    input  logic              id_jump,
    input  logic              id_halt,
    input  logic              ex_br_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         drain_cnt;
    logic [3:0]         drain_cnt_nxt;
    logic               stall;
    logic               issue;
    logic               hz;

    logic               ex_wr;
    logic [REG_AW-1:0]  ex_dst;
    logic               ex_ld;

    assign issue = id_valid & ~id_ex_bubble;

`ifdef FORWARDING_EN
    // Only a load still in EX cannot be forwarded in time.
    function automatic logic match(input logic [REG_AW-1:0] r);
        return (r != '0) && ex_wr && ex_ld && (ex_dst == r);
    endfunction
`else
    logic               mem_wr;
    logic [REG_AW-1:0]  mem_dst;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_wr  <= 1'b0;
            mem_dst <= '0;
        end else begin
            mem_wr  <= ex_wr;
            mem_dst <= ex_dst;
        end
    end

    // WB is absent: the regfile writes on the falling edge, so ID reads the new value.
    function automatic logic match(input logic [REG_AW-1:0] r);
        return (r != '0) && ((ex_wr && (ex_dst == r)) || (mem_wr && (mem_dst == r)));
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_wr  <= 1'b0;
            ex_dst <= '0;
            ex_ld  <= 1'b0;
        end else begin
            ex_wr  <= issue & id_reg_write;
            ex_dst <= issue ? id_dst : '0;
            ex_ld  <= issue & id_mem_read;
        end
    end

    // A load always writes its destination; the scoreboard relies on that.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!ex_ld || ex_wr)
                else $error("load in EX without register write");
        end
    end

    assign hz = id_valid & ((id_use_rs & match(id_rs)) | (id_use_rt & match(id_rt)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RUN;
            drain_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        if (ex_br_taken && (state != S_HALTED)) begin
            state_nxt     = S_RUN;
            drain_cnt_nxt = 4'd0;
        end else begin
            case (state)
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state_nxt     = S_HALTED;
                        drain_cnt_nxt = 4'd0;
                    end else begin
                        drain_cnt_nxt = drain_cnt + 4'd1;
                    end
                end
                S_RUN: begin
                    if (!hz && id_valid && id_halt) begin
                        state_nxt     = S_DRAIN;
                        drain_cnt_nxt = 4'd0;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        halted       = 1'b0;
        stall        = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (ex_br_taken && (state != S_HALTED)) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (state == S_HALTED) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            halted       = 1'b1;
        end else if (state == S_DRAIN) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (hz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall        = 1'b1;
        end else if (id_valid && id_halt) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (id_valid && id_jump) begin
            if_id_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule
